vga_out_stage: RTL and testbench
================================

Name: vga_out_stage

Overview:
- Parametrised VGA output stage between the rbzero core and the tile output pins.
- Delays a bundle {rgb, hsync_n, vsync_n, hblank, vblank} by a run-time selectable 0..MAX_DELAY clock cycles.
- Optionally forces rgb to black during blanking.
- A delay change takes effect only at the start of vsync, or immediately on request, so a frame never tears mid-scan.
- Supersedes the fixed single-register or bypass option.

Parameters:
- COLOR_BITS, 6, rgb width.
- MAX_DELAY, 3, deepest selectable delay; must be >= 1.
- DEFAULT_DELAY, 1, delay in force after reset; must be <= MAX_DELAY.
- DW, $clog2(MAX_DELAY+1), delay-select width (derived, localparam).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_rgb  in  COLOR_BITS  pixel colour from core.
- i_hsync_n  in  1  active-low hsync.
- i_vsync_n  in  1  active-low vsync.
- i_hblank  in  1  horizontal blanking.
- i_vblank  in  1  vertical blanking.
- i_delay_sel  in  DW  requested delay, in cycles.
- i_apply_now  in  1  apply i_delay_sel this cycle, without waiting for vsync.
- i_blank_en  in  1  force output rgb to 0 while blanking.
- o_rgb  out  COLOR_BITS  delayed/blanked colour.
- o_hsync_n  out  1  delayed hsync.
- o_vsync_n  out  1  delayed vsync.
- o_hblank  out  1  delayed hblank.
- o_vblank  out  1  delayed vblank.
- o_delay_cur  out  DW  delay currently in force.
- o_frame_tick  out  1  one-cycle pulse per vsync assertion.

Behaviour:
- One clock; reset is synchronous and active-high, ports named clk and reset.
- Delay line: MAX_DELAY register stages; stage k holds the input bundle from k cycles ago.
- Tap 0 is the live input bundle (combinational path); tap d is stage d.
- Outputs show tap[o_delay_cur]. Sync/blank alignment is preserved for every delay.
- Blanking rule is applied after the tap mux: o_rgb = (i_blank_en & (o_hblank | o_vblank)) ? 0 : tap_rgb. It uses the delayed blanks, so it is combinational on i_blank_en.
- Reset, on the clk edge while reset=1:
  - all stages go to the idle bundle: rgb=0, hsync_n=1, vsync_n=1, hblank=1, vblank=1;
  - o_delay_cur=DEFAULT_DELAY; o_frame_tick=0; vsync history=deasserted.
- With DEFAULT_DELAY >= 1, outputs are idle on the first cycle after reset.
- Reset mid-frame discards the pipeline contents and any pending request.
- Vsync edge: vs_prev is the registered ~i_vsync_n. Define edge = ~i_vsync_n & ~vs_prev (undelayed input side).
- Delay update: on a clk edge where (edge | i_apply_now), o_delay_cur <= clamp(i_delay_sel).
  - clamp(x) = (x > MAX_DELAY) ? MAX_DELAY : x.
  - Edge and apply_now together: a single update.
  - Otherwise o_delay_cur holds; i_delay_sel changes between vsyncs are ignored.
- Delay lines shift every cycle regardless of the selection, so switching to a deeper tap immediately yields valid history (no gap or refill).
- o_frame_tick: registered, equals edge of the previous cycle. It asserts exactly once per vsync assertion, one cycle after the edge cycle.
- No back-pressure and no handshake; throughput is one bundle per cycle.

Decomposition:
- Package vga_out_pkg:
  - localparam BUNDLE_W = COLOR_BITS+4;
  - bundle field offsets (RGB_LSB, HS_BIT, VS_BIT, HB_BIT, VB_BIT);
  - function idle_bundle(COLOR_BITS);
  - function clamp_delay.
- Sub-module vga_delay_line:
  - parameters WIDTH, DEPTH, IDLE;
  - inputs clk, reset, d; flattened output taps [DEPTH*WIDTH];
  - a pure shift register with synchronous reset to IDLE.
- Top level holds the tap mux, vsync-edge/delay-select control, and blanking.

Test Plan:
- Reset: hold reset=1 for 3 cycles, then release with inputs rgb=6'h3F, syncs=0, blanks=0. Required: the first post-reset cycle outputs o_rgb=0, o_hsync_n=1, o_vsync_n=1, blanks=1, o_delay_cur=1; the second cycle outputs rgb 6'h3F.
- Latency sweep: for d=0..3, apply via i_apply_now=1, then drive the rgb ramp 1,2,3,... Required: o_rgb equals the input from exactly d cycles earlier, and o_hsync_n is shifted by the same d.
- Deferred change: delay=1, set i_delay_sel=3 mid-frame. Required: o_delay_cur stays 1 until the cycle after i_vsync_n falls, then becomes 3. o_frame_tick=1 on that same cycle, only once, with i_vsync_n held low for 2 lines.
- Clamp: with MAX_DELAY=3 and DW=2 the clamp is unreachable, so re-parameterise to MAX_DELAY=4 (DW=3) and request 7. Required: o_delay_cur=4.
- Blanking: i_blank_en=1, rgb=6'h2A, hblank pulse of 10 cycles, delay 2. Required: o_rgb=0 for exactly 10 cycles, starting 2 cycles after the hblank rise. With i_blank_en=0, o_rgb=6'h2A throughout.
- Reset mid-frame with i_delay_sel=0 pending: required result is o_delay_cur=DEFAULT_DELAY and idle outputs; the pending request is not applied at the next vsync unless i_delay_sel still equals 0.

Source files
------------

// File: rtl/vga_out_pkg.sv
// Shared definitions for the VGA output stage: bundle layout and helpers.
// The bundle packs the control bits at the bottom so their offsets do not
// depend on the colour width; rgb sits above them.
package vga_out_pkg;

    // Number of non-colour bits in a bundle (hsync_n, vsync_n, hblank, vblank).
    localparam int CTRL_W  = 4;

    // Field offsets inside a bundle.
    localparam int VB_BIT  = 0;
    localparam int HB_BIT  = 1;
    localparam int VS_BIT  = 2;
    localparam int HS_BIT  = 3;
    localparam int RGB_LSB = 4;

    // Widest bundle the helpers below can describe.
    localparam int MAX_BUNDLE_W = 64;

    // Total bundle width for a given colour width.
    function automatic int bundle_w(input int color_bits);
        return color_bits + CTRL_W;
    endfunction

    // Idle bundle: black, syncs deasserted (high), both blanks asserted.
    // Returned zero-extended to MAX_BUNDLE_W; callers cast to their width.
    function automatic logic [MAX_BUNDLE_W-1:0] idle_bundle(input int color_bits);
        logic [MAX_BUNDLE_W-1:0] b;
        b = '0;
        for (int i = 0; i < color_bits; i++) begin
            b[RGB_LSB + i] = 1'b0;
        end
        b[HS_BIT] = 1'b1;
        b[VS_BIT] = 1'b1;
        b[HB_BIT] = 1'b1;
        b[VB_BIT] = 1'b1;
        return b;
    endfunction

    // Saturate a requested delay to the deepest available tap.
    function automatic int clamp_delay(input int x, input int max_d);
        return (x > max_d) ? max_d : x;
    endfunction

endpackage

// File: rtl/vga_out_stage_if.sv
// Pixel/sync bundle interface between the rbzero core side (master) and the
// VGA output stage (slave), including the delay/blank controls.
interface vga_out_stage_if #(
    parameter int COLOR_BITS = 6,
    parameter int DW         = 2
);
    logic [COLOR_BITS-1:0] i_rgb;
    logic                  i_hsync_n;
    logic                  i_vsync_n;
    logic                  i_hblank;
    logic                  i_vblank;
    logic [DW-1:0]         i_delay_sel;
    logic                  i_apply_now;
    logic                  i_blank_en;

    logic [COLOR_BITS-1:0] o_rgb;
    logic                  o_hsync_n;
    logic                  o_vsync_n;
    logic                  o_hblank;
    logic                  o_vblank;
    logic [DW-1:0]         o_delay_cur;
    logic                  o_frame_tick;

    // Core / pin-driver side: drives the raw bundle and controls.
    modport master (
        output i_rgb, i_hsync_n, i_vsync_n, i_hblank, i_vblank,
        output i_delay_sel, i_apply_now, i_blank_en,
        input  o_rgb, o_hsync_n, o_vsync_n, o_hblank, o_vblank,
        input  o_delay_cur, o_frame_tick
    );

    // Output stage side.
    modport slave (
        input  i_rgb, i_hsync_n, i_vsync_n, i_hblank, i_vblank,
        input  i_delay_sel, i_apply_now, i_blank_en,
        output o_rgb, o_hsync_n, o_vsync_n, o_hblank, o_vblank,
        output o_delay_cur, o_frame_tick
    );
endinterface

// File: rtl/vga_delay_line.sv
// Plain shift register: taps[k] holds the input from k+1 cycles ago.
// Synchronous reset loads every stage with IDLE.
module vga_delay_line #(
    parameter int               WIDTH = 10,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] IDLE  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       d,
    output logic [DEPTH*WIDTH-1:0] taps
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per cycle; reset flushes the whole line to IDLE.
    // NOTE: sequential state uses <= so every stage samples the pre-edge value
    // of its neighbour; blocking assignments would collapse the line.
    // NOTE: the stages are deliberately reset (not left as unreset storage)
    // so that a deep tap selected right after reset shows idle, not garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= IDLE;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_taps
        assign taps[k*WIDTH +: WIDTH] = stage[k];
    end

endmodule

// File: rtl/vga_out_stage.sv
// VGA output stage: delays the {rgb, syncs, blanks} bundle by a run-time
// selectable 0..MAX_DELAY cycles and optionally blacks out rgb in blanking.
// Delay changes land at the start of vsync (or at once on apply_now) so a
// frame is never torn mid-scan.
module vga_out_stage
    import vga_out_pkg::*;
#(
    parameter int COLOR_BITS    = 6,
    parameter int MAX_DELAY     = 3,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic            clk,
    input  logic            reset,
    vga_out_stage_if.slave  bus
);

    localparam int DW       = $clog2(MAX_DELAY + 1);
    localparam int BUNDLE_W = bundle_w(COLOR_BITS);
    localparam logic [BUNDLE_W-1:0] IDLE = BUNDLE_W'(idle_bundle(COLOR_BITS));

    logic [BUNDLE_W-1:0]           live;
    logic [BUNDLE_W-1:0]           tap_sel;
    logic [MAX_DELAY*BUNDLE_W-1:0] taps;

    logic [DW-1:0] delay_cur;
    logic          vs_prev;
    logic          vs_edge;
    logic          frame_tick;

    assign live = {bus.i_rgb, bus.i_hsync_n, bus.i_vsync_n, bus.i_hblank, bus.i_vblank};

    vga_delay_line #(
        .WIDTH (BUNDLE_W),
        .DEPTH (MAX_DELAY),
        .IDLE  (IDLE)
    ) u_delay_line (
        .clk   (clk),
        .reset (reset),
        .d     (live),
        .taps  (taps)
    );

    // Tap mux: 0 selects the live bundle, k selects the k-cycle-old stage.
    // NOTE: tap_sel gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        tap_sel = live;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (delay_cur == DW'(k)) begin
                tap_sel = taps[(k-1)*BUNDLE_W +: BUNDLE_W];
            end
        end
    end

    // Vsync assertion seen on the undelayed input side.
    assign vs_edge = ~bus.i_vsync_n & ~vs_prev;

    // Delay selection and frame tick; updates only at vsync start or on request.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_cur  <= DW'(DEFAULT_DELAY);
            vs_prev    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_prev    <= ~bus.i_vsync_n;
            frame_tick <= vs_edge;
            if (vs_edge | bus.i_apply_now) begin
                delay_cur <= DW'(clamp_delay(int'(bus.i_delay_sel), MAX_DELAY));
            end
        end
    end

    assign bus.o_hsync_n    = tap_sel[HS_BIT];
    assign bus.o_vsync_n    = tap_sel[VS_BIT];
    assign bus.o_hblank     = tap_sel[HB_BIT];
    assign bus.o_vblank     = tap_sel[VB_BIT];
    assign bus.o_delay_cur  = delay_cur;
    assign bus.o_frame_tick = frame_tick;

    // Blanking uses the delayed blanks so it lines up with the delayed pixels.
    assign bus.o_rgb = (bus.i_blank_en & (tap_sel[HB_BIT] | tap_sel[VB_BIT]))
                     ? '0 : tap_sel[RGB_LSB +: COLOR_BITS];

endmodule

// File: tb/tb_vga_out_stage.sv
// Self-checking bench for vga_out_stage: a history-queue model checked every
// cycle plus directed literal checks; a second instance covers clamping.
module tb_vga_out_stage;

    localparam int CB      = 6;
    localparam int MAXD    = 3;
    localparam int DEFD    = 1;
    localparam int DW      = 2;
    localparam int MAXD4   = 4;
    localparam int DW4     = 3;

    typedef struct packed {
        logic [CB-1:0] rgb;
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
    } bundle_t;

    localparam bundle_t IDLE_B = '{rgb: '0, hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1};

    logic clk = 1'b0;
    logic reset;
    logic reset4;

    vga_out_stage_if #(.COLOR_BITS(CB), .DW(DW))  bus  ();
    vga_out_stage_if #(.COLOR_BITS(CB), .DW(DW4)) bus4 ();

    vga_out_stage #(.COLOR_BITS(CB), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vga_out_stage #(.COLOR_BITS(CB), .MAX_DELAY(MAXD4), .DEFAULT_DELAY(DEFD)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bundle_t hist[$];       // hist[0] = bundle seen one cycle ago
    int      m_delay;
    bit      m_tick;
    bit      m_vs_low_prev;
    bit      m_ok = 1'b0;

    function automatic bundle_t live_bundle();
        bundle_t b;
        b.rgb = bus.i_rgb;
        b.hs  = bus.i_hsync_n;
        b.vs  = bus.i_vsync_n;
        b.hb  = bus.i_hblank;
        b.vb  = bus.i_vblank;
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist = {};
            for (int k = 0; k < MAXD; k++) hist.push_back(IDLE_B);
            m_delay       = DEFD;
            m_tick        = 1'b0;
            m_vs_low_prev = 1'b0;
            m_ok          = 1'b1;
        end else if (m_ok) begin
            bit starts;
            starts = !bus.i_vsync_n && !m_vs_low_prev;
            m_tick = starts;
            if (starts || bus.i_apply_now)
                m_delay = (int'(bus.i_delay_sel) > MAXD) ? MAXD : int'(bus.i_delay_sel);
            m_vs_low_prev = !bus.i_vsync_n;
            hist.push_front(live_bundle());
            void'(hist.pop_back());
        end
    end

    // Compare every cycle, mid-cycle, once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ok) begin
            bundle_t t;
            logic [CB-1:0] exp_rgb;
            t = (m_delay == 0) ? live_bundle() : hist[m_delay-1];
            exp_rgb = (bus.i_blank_en && (t.hb || t.vb)) ? '0 : t.rgb;
            check("m_rgb",   bus.o_rgb,        exp_rgb);
            check("m_hs",    bus.o_hsync_n,    t.hs);
            check("m_vs",    bus.o_vsync_n,    t.vs);
            check("m_hb",    bus.o_hblank,     t.hb);
            check("m_vb",    bus.o_vblank,     t.vb);
            check("m_delay", bus.o_delay_cur,  m_delay);
            check("m_tick",  bus.o_frame_tick, m_tick);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus + literal checks ----------------
    initial begin
        int ticks;
        int zeros;
        int first_zero;

        reset = 1'b1;
        reset4 = 1'b1;
        bus.i_rgb = '0;  bus.i_hsync_n = 1'b1; bus.i_vsync_n = 1'b1;
        bus.i_hblank = 1'b0; bus.i_vblank = 1'b0;
        bus.i_delay_sel = 2'd1; bus.i_apply_now = 1'b0; bus.i_blank_en = 1'b0;
        bus4.i_rgb = '0; bus4.i_hsync_n = 1'b1; bus4.i_vsync_n = 1'b1;
        bus4.i_hblank = 1'b0; bus4.i_vblank = 1'b0;
        bus4.i_delay_sel = 3'd1; bus4.i_apply_now = 1'b0; bus4.i_blank_en = 1'b0;

        // Reset for 3 cycles, then release with a fully active bundle.
        repeat (3) step();
        reset = 1'b0;
        bus.i_rgb = 6'h3F; bus.i_hsync_n = 1'b0; bus.i_vsync_n = 1'b0;
        bus.i_hblank = 1'b0; bus.i_vblank = 1'b0;
        @(negedge clk);
        check("rst_rgb",   bus.o_rgb,       6'h00);
        check("rst_hs",    bus.o_hsync_n,   1'b1);
        check("rst_vs",    bus.o_vsync_n,   1'b1);
        check("rst_hb",    bus.o_hblank,    1'b1);
        check("rst_vb",    bus.o_vblank,    1'b1);
        check("rst_delay", bus.o_delay_cur, 2'd1);
        step();
        @(negedge clk);
        check("rst_rgb2",  bus.o_rgb,        6'h3F);
        check("rst_tick",  bus.o_frame_tick, 1'b1);
        step();

        // Latency sweep: ramp rgb and a period-3 hsync pattern for each delay.
        bus.i_vsync_n = 1'b1; bus.i_hsync_n = 1'b1;
        for (int d = 0; d <= MAXD; d++) begin
            bus.i_delay_sel = DW'(d);
            bus.i_apply_now = 1'b1;
            @(negedge clk);
            step();
            bus.i_apply_now = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                bus.i_rgb     = CB'(i);
                bus.i_hsync_n = (i % 3) != 0;
                @(negedge clk);
                check("lat_delay", bus.o_delay_cur, d);
                if (i > d) begin
                    check("lat_rgb", bus.o_rgb, i - d);
                    check("lat_hs",  bus.o_hsync_n, ((i - d) % 3) != 0);
                end
                step();
            end
        end

        // Deferred change: request 3 mid-frame, lands one cycle after vsync falls.
        bus.i_hsync_n = 1'b1; bus.i_vsync_n = 1'b1;
        bus.i_delay_sel = 2'd1; bus.i_apply_now = 1'b1;
        @(negedge clk);
        step();
        bus.i_apply_now = 1'b0;
        bus.i_delay_sel = 2'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("def_hold", bus.o_delay_cur, 2'd1);
            step();
        end
        bus.i_vsync_n = 1'b0;
        @(negedge clk);
        check("def_edge_delay", bus.o_delay_cur, 2'd1);
        check("def_edge_tick",  bus.o_frame_tick, 1'b0);
        step();
        ticks = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("def_new_delay", bus.o_delay_cur, 2'd3);
                check("def_new_tick",  bus.o_frame_tick, 1'b1);
            end
            if (bus.o_frame_tick) ticks++;
            step();
        end
        check("def_tick_count", ticks, 1);
        bus.i_vsync_n = 1'b1;

        // Blanking at delay 2: a 10-cycle hblank pulse blacks 10 cycles, 2 late.
        bus.i_delay_sel = 2'd2; bus.i_apply_now = 1'b1;
        bus.i_rgb = 6'h2A; bus.i_hblank = 1'b0; bus.i_vblank = 1'b0;
        bus.i_blank_en = 1'b1;
        @(negedge clk);
        step();
        bus.i_apply_now = 1'b0;
        repeat (3) begin @(negedge clk); step(); end
        zeros = 0; first_zero = -1;
        for (int t = 0; t < 25; t++) begin
            bus.i_hblank = (t < 10);
            @(negedge clk);
            check("blk_rgb", bus.o_rgb, (t >= 2 && t < 12) ? 6'h00 : 6'h2A);
            if (bus.o_rgb == 6'h00) begin
                zeros++;
                if (first_zero < 0) first_zero = t;
            end
            step();
        end
        check("blk_zero_count", zeros, 10);
        check("blk_first_zero", first_zero, 2);
        bus.i_blank_en = 1'b0;
        for (int t = 0; t < 25; t++) begin
            bus.i_hblank = (t < 10);
            @(negedge clk);
            check("noblk_rgb", bus.o_rgb, 6'h2A);
            step();
        end
        bus.i_hblank = 1'b0;

        // Randomised traffic, occasional resets and vsync pulses.
        for (int n = 0; n < 1500; n++) begin
            bus.i_rgb       = CB'($urandom);
            bus.i_hsync_n   = ($urandom_range(0, 7) != 0);
            bus.i_hblank    = ($urandom_range(0, 3) == 0);
            bus.i_vblank    = ($urandom_range(0, 7) == 0);
            bus.i_blank_en  = $urandom_range(0, 1) == 1;
            bus.i_delay_sel = DW'($urandom);
            bus.i_apply_now = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) bus.i_vsync_n = ~bus.i_vsync_n;
            reset           = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            step();
        end
        reset = 1'b0;
        bus.i_apply_now = 1'b0;

        // Reset mid-frame with a pending request for 0.
        bus.i_vsync_n = 1'b1; bus.i_blank_en = 1'b0;
        bus.i_delay_sel = 2'd3; bus.i_apply_now = 1'b1;
        @(negedge clk);
        step();
        bus.i_apply_now = 1'b0;
        bus.i_delay_sel = 2'd0;
        @(negedge clk);
        step();
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        bus.i_rgb = 6'h15; bus.i_hsync_n = 1'b0; bus.i_hblank = 1'b0; bus.i_vblank = 1'b0;
        bus.i_delay_sel = 2'd2;
        @(negedge clk);
        check("mrst_delay", bus.o_delay_cur, 2'd1);
        check("mrst_rgb",   bus.o_rgb,       6'h00);
        check("mrst_hs",    bus.o_hsync_n,   1'b1);
        check("mrst_hb",    bus.o_hblank,    1'b1);
        check("mrst_vb",    bus.o_vblank,    1'b1);
        step();
        bus.i_vsync_n = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        check("mrst_new_delay", bus.o_delay_cur, 2'd2);
        step();

        // Clamp on the deeper instance: request 7 with MAX_DELAY=4.
        @(negedge clk);
        check("clamp_default", bus4.o_delay_cur, 3'd1);
        step();
        reset4 = 1'b0;
        bus4.i_delay_sel = 3'd7; bus4.i_apply_now = 1'b1;
        @(negedge clk);
        step();
        bus4.i_apply_now = 1'b0;
        @(negedge clk);
        check("clamp_7", bus4.o_delay_cur, 3'd4);
        step();
        bus4.i_delay_sel = 3'd3; bus4.i_apply_now = 1'b1;
        @(negedge clk);
        step();
        bus4.i_apply_now = 1'b0;
        @(negedge clk);
        check("clamp_3", bus4.o_delay_cur, 3'd3);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
